// File: rtl/in_unit_pipe_buff.sv
// in_unit_pipe_buff: elastic pipeline buffer between the pixel-input unit and
// the dimming algorithm core. DEPTH register stages carry pixel payload plus
// duty/address sideband. Each stage has its own valid bit. Empty stages collapse
// under back-pressure, and iFlush (ALG_rst) clears the pipe synchronously.
// Optional statistics (oOccupancy, oStallCnt) are built only when the
// PIPE_STAT_EN macro is defined.
module in_unit_pipe_buff #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned SIDE_W = 36,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         iODCK,
  input  logic                         iRST_N,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic [DATA_W-1:0]            iData,
  input  logic [SIDE_W-1:0]            iSide,
  input  logic                         iFlush,
  output logic                         oValid,
  input  logic                         iReady,
`ifdef PIPE_STAT_EN
  output logic [$clog2(DEPTH+1)-1:0]   oOccupancy,
  output logic [15:0]                  oStallCnt,
`endif
  output logic [DATA_W-1:0]            oData,
  output logic [SIDE_W-1:0]            oSide
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  vld;
  logic [DEPTH-1:0]  vldNext;
  logic [DEPTH-1:0]  vIn;
  logic [DEPTH-1:0]  load;
  logic [DEPTH:0]    rdy;
  logic              chainAcc;
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [SIDE_W-1:0] sideQ [DEPTH];

  // Ready chain: a stage can take a beat if it is empty or its successor moves.
  always_comb begin
    rdy        = '0;
    chainAcc   = iReady;
    rdy[DEPTH] = iReady;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      chainAcc = chainAcc | ~vld[k];
      rdy[k]   = chainAcc;
    end
  end

  // Next valid bits and load enables; flush wins over any load.
  always_comb begin
    vIn     = '0;
    vldNext = vld;
    load    = '0;
    vIn[0]  = iValid;
    for (int k = 1; k < int'(DEPTH); k++) begin
      vIn[k] = vld[k-1];
    end
    if (iFlush) begin
      vldNext = '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (rdy[k]) begin
          vldNext[k] = vIn[k];
          load[k]    = vIn[k];
        end
      end
    end
  end

  // Stage valid bits.
  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      vld <= '0;
    end else begin
      vld <= vldNext;
    end
  end

  // Stage payload registers load only with valid data; they hold across flush.
  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        dataQ[k] <= '0;
        sideQ[k] <= '0;
      end
    end else begin
      if (load[0]) begin
        dataQ[0] <= iData;
        sideQ[0] <= iSide;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (load[k]) begin
          dataQ[k] <= dataQ[k-1];
          sideQ[k] <= sideQ[k-1];
        end
      end
    end
  end

  assign oReady = rdy[0] & ~iFlush;
  assign oValid = vld[DEPTH-1];
  assign oData  = dataQ[DEPTH-1];
  assign oSide  = sideQ[DEPTH-1];

`ifdef PIPE_STAT_EN
  function automatic logic [OCC_W-1:0] popCnt(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      n = n + OCC_W'(v[k]);
    end
    return n;
  endfunction

  // Occupancy tracks the stage valid bits; stall counter saturates.
  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      oOccupancy <= '0;
      oStallCnt  <= '0;
    end else begin
      oOccupancy <= popCnt(vldNext);
      if (oValid && !iReady && (oStallCnt != 16'hFFFF)) begin
        oStallCnt <= oStallCnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_in_unit_pipe_buff.sv
// tb_in_unit_pipe_buff: drives a DEPTH=2 and a DEPTH=4 instance with shared
// stimulus and compares them against a queue-of-beats reference model.
// Statistics ports are checked when PIPE_STAT_EN is defined.
module tb_in_unit_pipe_buff;

  localparam int unsigned DW = 192;
  localparam int unsigned SW = 36;

  logic          clk = 1'b0;
  logic          rstN;
  logic          iValid, iFlush, iReady;
  logic [DW-1:0] iData;
  logic [SW-1:0] iSide;

  logic          oReadyU [2];
  logic          oValidU [2];
  logic [DW-1:0] oDataU  [2];
  logic [SW-1:0] oSideU  [2];
`ifdef PIPE_STAT_EN
  logic [1:0]    occ2;
  logic [2:0]    occ4;
  logic [15:0]   stall2, stall4;
`endif

  int nVec = 0;
  int nErr = 0;

  // Model: per instance, an ordered list of beats (head first) with stage positions.
  logic [DW-1:0] mD [2][8];
  logic [SW-1:0] mS [2][8];
  int            mP [2][8];
  int            mN [2];
  int            mStall [2];

  always #5 clk = ~clk;

  in_unit_pipe_buff #(.DATA_W(DW), .SIDE_W(SW), .DEPTH(2)) u2 (
    .iODCK(clk), .iRST_N(rstN), .iValid(iValid), .oReady(oReadyU[0]),
    .iData(iData), .iSide(iSide), .iFlush(iFlush), .oValid(oValidU[0]),
    .iReady(iReady),
`ifdef PIPE_STAT_EN
    .oOccupancy(occ2), .oStallCnt(stall2),
`endif
    .oData(oDataU[0]), .oSide(oSideU[0])
  );

  in_unit_pipe_buff #(.DATA_W(DW), .SIDE_W(SW), .DEPTH(4)) u4 (
    .iODCK(clk), .iRST_N(rstN), .iValid(iValid), .oReady(oReadyU[1]),
    .iData(iData), .iSide(iSide), .iFlush(iFlush), .oValid(oValidU[1]),
    .iReady(iReady),
`ifdef PIPE_STAT_EN
    .oOccupancy(occ4), .oStallCnt(stall4),
`endif
    .oData(oDataU[1]), .oSide(oSideU[1])
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int depOf(input int u);
    return (u == 0) ? 2 : 4;
  endfunction

  function automatic logic [DW-1:0] rndData();
    logic [DW-1:0] d;
    for (int i = 0; i < 6; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [SW-1:0] rndSide();
    logic [63:0] s;
    s = {$urandom, $urandom};
    return s[SW-1:0];
  endfunction

  task automatic clearModel();
    for (int u = 0; u < 2; u++) begin
      mN[u] = 0;
      mStall[u] = 0;
    end
  endtask

  task automatic chkResetOutputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("%s oValid/D%0d", tag, depOf(u)), 256'(oValidU[u]), 256'(0));
      chk($sformatf("%s oData/D%0d", tag, depOf(u)), 256'(oDataU[u]), 256'(0));
      chk($sformatf("%s oSide/D%0d", tag, depOf(u)), 256'(oSideU[u]), 256'(0));
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic r, input logic f);
    int  dep, newPrev, np;
    bit  expRdy, expVld, acc;
    @(negedge clk);
    iValid = v; iData = d; iSide = s; iReady = r; iFlush = f;
    #1;
    for (int u = 0; u < 2; u++) begin
      dep    = depOf(u);
      expRdy = !f && ((mN[u] < dep) || r);
      expVld = (mN[u] > 0) && (mP[u][0] == dep - 1);
      chk($sformatf("oReady/D%0d", dep), 256'(oReadyU[u]), 256'(expRdy));
      chk($sformatf("oValid/D%0d", dep), 256'(oValidU[u]), 256'(expVld));
      if (expVld) begin
        chk($sformatf("oData/D%0d", dep), 256'(oDataU[u]), 256'(mD[u][0]));
        chk($sformatf("oSide/D%0d", dep), 256'(oSideU[u]), 256'(mS[u][0]));
      end
`ifdef PIPE_STAT_EN
      chk($sformatf("oOccupancy/D%0d", dep), (u == 0) ? 256'(occ2) : 256'(occ4), 256'(mN[u]));
      chk($sformatf("oStallCnt/D%0d", dep), (u == 0) ? 256'(stall2) : 256'(stall4), 256'(mStall[u]));
`endif
      if (expVld && !r && mStall[u] < 65535) mStall[u]++;
      acc = v && expRdy;
      if (f) begin
        mN[u] = 0;
      end else begin
        // Each beat advances one stage unless blocked by the beat ahead of it.
        newPrev = r ? dep + 1 : dep;
        for (int i = 0; i < mN[u]; i++) begin
          np = (mP[u][i] + 1 < newPrev - 1) ? mP[u][i] + 1 : newPrev - 1;
          mP[u][i] = np;
          newPrev  = np;
        end
        if (mN[u] > 0 && mP[u][0] == dep) begin
          for (int i = 1; i < mN[u]; i++) begin
            mD[u][i-1] = mD[u][i];
            mS[u][i-1] = mS[u][i];
            mP[u][i-1] = mP[u][i];
          end
          mN[u]--;
        end
        if (acc) begin
          mD[u][mN[u]] = d;
          mS[u][mN[u]] = s;
          mP[u][mN[u]] = 0;
          mN[u]++;
        end
      end
    end
  endtask

  task automatic idle(input logic r, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rndData(), rndSide(), r, 1'b0);
  endtask

  task automatic randPhase(input int pv, input int pr, input int pf, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom_range(99) < pv), rndData(), rndSide(),
            ($urandom_range(99) < pr), ($urandom_range(99) < pf));
    end
  endtask

  initial begin
    rstN = 1'b0; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b0;
    iData = '0; iSide = '0;
    clearModel();

    // Reset with random inputs: outputs must be zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iValid = 1'(($urandom) & 1); iReady = 1'(($urandom) & 1); iFlush = 1'(($urandom) & 1);
      iData = rndData(); iSide = rndSide();
      #1;
      chkResetOutputs("reset");
    end
    @(negedge clk);
    iValid = 1'b0; iFlush = 1'b0; iReady = 1'b1;
    rstN = 1'b1;

    // Streaming D=1,2,3 with the sink always ready.
    for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i), SW'(i), 1'b1, 1'b0);
    idle(1'b1, 6);

    // Back-pressure: four offered beats with the sink stalled, then drain.
    for (int i = 10; i < 14; i++) cycle(1'b1, DW'(i), SW'(i), 1'b0, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, 8);

    // Bubble compaction: one beat, stall, then three more beats while stalled.
    cycle(1'b1, DW'(20), SW'(20), 1'b0, 1'b0);
    idle(1'b0, 4);
    for (int i = 21; i < 24; i++) cycle(1'b1, DW'(i), SW'(i), 1'b0, 1'b0);
    idle(1'b0, 2);
    idle(1'b1, 8);

    // Flush a full pipe with a beat offered in the flush cycle.
    for (int i = 30; i < 36; i++) cycle(1'b1, DW'(i), SW'(i), 1'b0, 1'b0);
    cycle(1'b1, DW'(99), SW'(99), 1'b0, 1'b1);
    idle(1'b0, 2);
    idle(1'b1, 6);
    // Flush while a beat is being delivered.
    for (int i = 40; i < 44; i++) cycle(1'b1, DW'(i), SW'(i), 1'b0, 1'b0);
    cycle(1'b1, DW'(98), SW'(98), 1'b1, 1'b1);
    idle(1'b1, 6);

    // Random traffic under varying load.
    randPhase(90, 90, 0, 400);
    randPhase(90, 30, 0, 400);
    randPhase(30, 80, 0, 400);
    randPhase(70, 50, 3, 600);
    randPhase(100, 100, 0, 200);

    // Asynchronous reset mid-stream.
    randPhase(90, 20, 0, 20);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chkResetOutputs("midreset");
    clearModel();
    @(negedge clk);
    iValid = 1'b0; iFlush = 1'b0;
    rstN = 1'b1;
    randPhase(80, 60, 2, 300);

`ifdef PIPE_STAT_EN
    // Long stall: counter must saturate and stay at 16'hFFFF.
    idle(1'b1, 6);
    cycle(1'b1, DW'(77), SW'(77), 1'b0, 1'b0);
    idle(1'b0, 70000);
    #1;
    chk("stallSat/D2", 256'(stall2), 256'(16'hFFFF));
    chk("stallSat/D4", 256'(stall4), 256'(16'hFFFF));
    idle(1'b1, 8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
